// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry and cell encoding shared by the playfield logic
package tetris_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W = 8;
  localparam int COLOUR_W = 6;
  localparam int ROW_W = 5;
  localparam int COL_W = 4;
  localparam logic [COLOUR_W-1:0] CELL_EMPTY = 6'd0;
endpackage

// File: rtl/line_clear_if.sv
// line_clear_if: start/status handshake plus the board RAM port of the line clearer
interface line_clear_if;
  import tetris_pkg::*;
  logic start;
  logic [ADDR_W-1:0] ram_addr;
  logic [COLOUR_W-1:0] ram_rdata;
  logic [COLOUR_W-1:0] ram_wdata;
  logic ram_wren;
  logic busy;
  logic done;
  logic [2:0] lines_cleared;
  modport master (output start, ram_rdata, input ram_addr, ram_wdata, ram_wren, busy, done, lines_cleared);
  modport slave (input start, ram_rdata, output ram_addr, ram_wdata, ram_wren, busy, done, lines_cleared);
endinterface

// File: rtl/line_clear_board_addr.sv
// board_addr: maps a (row, col) board coordinate to its row-major RAM address
module board_addr
  import tetris_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);
  assign addr = ADDR_W'(row) * ADDR_W'(BOARD_W) + ADDR_W'(col);
endmodule

// File: rtl/line_clear.sv
// line_clear: scans the board bottom-up, removes full rows and drops everything above them
module line_clear
  import tetris_pkg::*;
(
  input logic clk,
  input logic reset,
  line_clear_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE} state_t;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, dst_q, dst_d, arow;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0] lc_q, lc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLOUR_W-1:0] wdata_q, wdata_d;
  logic wren_q, wren_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    dst_d = dst_q;
    lc_d = lc_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SCAN_RD;
        row_d = LAST_ROW;
        col_d = '0;
        lc_d = '0;
      end
      SCAN_RD: state_d = SCAN_CHK;
      SCAN_CHK: if (bus.ram_rdata == CELL_EMPTY) begin
        state_d = (row_q == '0) ? DONE : SCAN_RD;
        row_d = (row_q == '0) ? row_q : row_q - 5'd1;
        col_d = '0;
      end else if (col_q != LAST_COL) begin
        state_d = SCAN_RD;
        col_d = col_q + 4'd1;
      end else begin
        state_d = (row_q == '0) ? CLR_TOP : SHIFT_RD;
        dst_d = row_q;
        col_d = '0;
        lc_d = (lc_q == 3'd7) ? lc_q : lc_q + 3'd1;
      end
      SHIFT_RD: state_d = SHIFT_WR;
      SHIFT_WR: if (col_q == LAST_COL) begin
        state_d = (dst_q == 5'd1) ? CLR_TOP : SHIFT_RD;
        dst_d = dst_q - 5'd1;
        col_d = '0;
      end else begin
        state_d = SHIFT_RD;
        col_d = col_q + 4'd1;
      end
      // row_q still names the row that was full, so the re-scan starts there
      CLR_TOP: if (col_q == LAST_COL) begin
        state_d = SCAN_RD;
        col_d = '0;
      end else col_d = col_q + 4'd1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they belong to
  assign arow = (state_d == SHIFT_RD) ? dst_d - 5'd1 :
                (state_d == SHIFT_WR) ? dst_d :
                (state_d == CLR_TOP) ? '0 : row_d;
  board_addr u_addr (.row(arow), .col(col_d), .addr(addr_d));
  always_comb begin
    wren_d = (state_d == SHIFT_WR) || (state_d == CLR_TOP);
    wdata_d = (state_d == SHIFT_WR) ? bus.ram_rdata : CELL_EMPTY;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      dst_q <= '0;
      lc_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wren_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      dst_q <= dst_d;
      lc_q <= lc_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wren_q <= wren_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.ram_addr = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_wren = wren_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.lines_cleared = lc_q;
endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: board scenarios checked against a row-level gravity model via a scoreboard
module tb_line_clear;
  typedef struct {
    logic [19:0] full;
    logic [5:0] colour;
    int prow;
    int xrow;
    int xcol;
    logic [5:0] xval;
    logic [2:0] exp_lc;
  } vec_t;
  typedef struct {
    logic [2:0] lc;
    int cyc;
    int wr;
  } exp_t;
  logic clk, reset;
  logic ld_we;
  logic [7:0] ld_addr;
  logic [5:0] ld_data;
  logic [5:0] mem [256];
  logic [5:0] init_b [200];
  logic [5:0] exp_b [200];
  vec_t vt [7];
  exp_t sb [$];
  int n_chk, n_fail, m_cyc, m_wr;
  line_clear_if bus ();
  line_clear dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // RAM: reads are asynchronous, so data is ready by the edge after the address settles
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
    else if (ld_we) mem[ld_addr] <= ld_data;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic build(input vec_t v);
    for (int a = 0; a < 200; a++) init_b[a] = 6'd0;
    for (int r = 0; r < 20; r++)
      if (v.full[r]) for (int c = 0; c < 10; c++) init_b[r*10+c] = v.colour;
    if (v.prow >= 0) for (int c = 0; c < 9; c++) init_b[v.prow*10+c] = 6'd3;
    if (v.xrow >= 0) init_b[v.xrow*10+v.xcol] = v.xval;
  endtask
  task automatic model();
    int r, n;
    for (int a = 0; a < 200; a++) exp_b[a] = init_b[a];
    m_cyc = 1;
    m_wr = 0;
    r = 19;
    while (r >= 0) begin
      n = 0;
      while (n < 10 && exp_b[r*10+n] != 6'd0) n++;
      m_cyc += 2 * ((n < 10) ? n + 1 : 10);
      if (n == 10) begin
        m_cyc += 20 * r + 10;
        m_wr += 10 * r + 10;
        for (int rr = r; rr > 0; rr--)
          for (int c = 0; c < 10; c++) exp_b[rr*10+c] = exp_b[(rr-1)*10+c];
        for (int c = 0; c < 10; c++) exp_b[c] = 6'd0;
      end else r--;
    end
  endtask
  task automatic load();
    for (int a = 0; a < 200; a++) begin
      @(negedge clk);
      ld_we = 1'b1;
      ld_addr = 8'(a);
      ld_data = init_b[a];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask
  task automatic run_vec(input int i, input bit hold);
    int cyc, wr, bad;
    bit seen;
    exp_t e;
    build(vt[i]);
    model();
    load();
    @(negedge clk);
    bus.start = 1'b1;
    sb.push_back('{vt[i].exp_lc, m_cyc, m_wr});
    cyc = 0;
    wr = 0;
    seen = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.busy) cyc++;
      if (bus.ram_wren) wr++;
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk($sformatf("v%0d done_seen", i), int'(seen), 1);
    chk($sformatf("v%0d lines_cleared", i), int'(bus.lines_cleared), int'(e.lc));
    chk($sformatf("v%0d busy_cycles", i), cyc, e.cyc);
    chk($sformatf("v%0d write_cycles", i), wr, e.wr);
    @(negedge clk);
    chk($sformatf("v%0d done_pulse", i), int'(bus.done), 0);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d idle_busy", i), int'(bus.busy), 0);
    chk($sformatf("v%0d lc_held", i), int'(bus.lines_cleared), int'(e.lc));
    bad = 0;
    for (int a = 0; a < 200; a++) if (mem[a] !== exp_b[a]) bad++;
    chk($sformatf("v%0d board_mismatch_cells", i), bad, 0);
  endtask
  initial begin
    bit seen;
    vt[0] = '{20'h00000, 6'd0, -1, -1, 0, 6'd0, 3'd0};
    vt[1] = '{20'h80000, 6'd5, -1, 18, 3, 6'd2, 3'd1};
    vt[2] = '{20'hA0000, 6'd7, -1, 18, 0, 6'd1, 3'd2};
    vt[3] = '{20'hF0000, 6'd4, -1, -1, 0, 6'd0, 3'd4};
    vt[4] = '{20'h00001, 6'd1, -1, -1, 0, 6'd0, 3'd1};
    vt[5] = '{20'hFF000, 6'd2, -1, 5, 9, 6'd6, 3'd7};
    vt[6] = '{20'h80000, 6'd6, 18, 10, 9, 6'd4, 3'd1};
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    ld_we = 1'b0;
    ld_addr = 8'd0;
    ld_data = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst wren", int'(bus.ram_wren), 0);
    chk("rst addr", int'(bus.ram_addr), 0);
    chk("rst wdata", int'(bus.ram_wdata), 0);
    chk("rst lines_cleared", int'(bus.lines_cleared), 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) run_vec(i, 1'b0);
    run_vec(1, 1'b1);
    build(vt[1]);
    load();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 500; k++) begin
      if (bus.ram_wren) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midshift wren_seen", int'(seen), 1);
    reset = 1'b1;
    #1;
    chk("midshift wren", int'(bus.ram_wren), 0);
    chk("midshift busy", int'(bus.busy), 0);
    chk("midshift addr", int'(bus.ram_addr), 0);
    chk("midshift lines_cleared", int'(bus.lines_cleared), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset busy", int'(bus.busy), 0);
    run_vec(0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/line_clear.md
LINE_CLEAR -- requirements
Module: line_clear

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to scan the board after a piece locks; sampled only in IDLE.
REQ-004 ram_addr  output  8  board RAM address, row*10+col; row 0 = top, col 0 = left.
REQ-005 ram_rdata  input  6  board RAM read data; valid one cycle after ram_addr is presented.
REQ-006 ram_wdata  output  6  board RAM write data (cell colour; 0 = empty).
REQ-007 ram_wren  output  1  board RAM write enable; high for exactly one cycle per cell written.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when the scan finishes.
REQ-010 lines_cleared  output  3  count of rows removed by the last operation; held until the next start.

Function
REQ-011 Board is 10 columns x 20 rows; a cell is occupied when nonzero; a row is full when all 10 cells are occupied.
REQ-012 States: IDLE, SCAN_RD, SCAN_CHK, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE.
REQ-013 IDLE: start=1 -> SCAN_RD with row=19, col=0; lines_cleared cleared to 0 on the same edge.
REQ-014 SCAN_RD drives ram_addr; SCAN_CHK samples ram_rdata; each scanned cell costs exactly 2 cycles.
REQ-015 SCAN_CHK, cell empty -> row abandoned early; if row=0 -> DONE, else row-1, col=0, SCAN_RD.
REQ-016 SCAN_CHK, cell occupied, col<9 -> col+1, SCAN_RD; col=9 -> row full -> SHIFT_RD with dst=row, col=0; lines_cleared+1, saturating at 7.
REQ-017 SHIFT_RD addresses (dst-1, col); SHIFT_WR writes the returned data to (dst, col) with ram_wren=1; 2 cycles per cell, cols 0..9, then dst-1.
REQ-018 When dst reaches 0 (including a full row 0) -> CLR_TOP: writes 0 to row 0, cols 0..9, one cell per cycle.
REQ-019 After CLR_TOP -> SCAN_RD at the same row index that was full (re-scan, no decrement), col=0.
REQ-020 DONE: done=1 for one cycle -> IDLE.
REQ-021 start while busy is ignored; no queuing.
REQ-022 All outputs are registered; ram_wren=0 outside SHIFT_WR and CLR_TOP.
REQ-023 Empty board: done is high 41 cycles after the edge that sampled start (40 scan cycles + DONE).
REQ-024 The caller owns RAM-port arbitration; this block assumes exclusive port access while busy.

Reset
REQ-025 reset asserted -> IDLE immediately; busy=0, done=0, ram_wren=0, ram_addr=0, ram_wdata=0, lines_cleared=0.
REQ-026 Reset mid-shift abandons the operation; partially shifted RAM contents are not repaired.

Structure
REQ-027 Shared package tetris_pkg holds BOARD_W=10, BOARD_H=20, CELL_EMPTY=6'd0, ADDR_W=8, COLOUR_W=6.
REQ-028 The state encoding is local to line_clear.
REQ-029 One sub-module, board_addr (combinational row, col -> address), shared with the collision and draw logic.

Verification
REQ-030 Empty board, start pulse -> done at +41 cycles, lines_cleared=0, zero write cycles.
REQ-031 Row 19 full (colour 5), row 18 col 3 = colour 2 -> done, lines_cleared=1; row 19 col 3 = 2, rest of row 19 = 0; rows 0 and 18 all 0.
REQ-032 Rows 19 and 17 full, row 18 col 0 = 1 -> lines_cleared=2; row 19 col 0 = 1; all other cells 0.
REQ-033 Rows 16..19 full -> lines_cleared=4; board empty; each full row is re-scanned at index 19.
REQ-034 Row 0 full only -> CLR_TOP is entered directly; row 0 = 0; lines_cleared=1.
REQ-035 Reset pulsed during SHIFT_WR -> ram_wren low in the same cycle, busy=0; a second start held during the run is ignored.
